// File: rtl/enemies_fire_scheduler.sv
// Enemy fire scheduler: a per-frame cooldown gates shots, a round-robin scan picks the
// next alive enemy, and a valid/ack handshake hands spawn coordinates and a free slot to the bullet movers.
module enemies_fire_scheduler #(
    parameter int NUM_ENEMIES     = 4,
    parameter int NUM_SLOTS       = 2,
    parameter int FIRE_COOLDOWN   = 40,
    parameter int OBJECT_WIDTH_X  = 30,
    parameter int OBJECT_HEIGHT_Y = 30
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic                      pause,
    input  logic [NUM_ENEMIES-1:0]    enemyAlive,
    input  logic [11*NUM_ENEMIES-1:0] enemyX,
    input  logic [11*NUM_ENEMIES-1:0] enemyY,
    input  logic [NUM_SLOTS-1:0]      slotDone,
    input  logic                      fireAck,
    output logic                      fireValid,
    output logic [1:0]                fireSlot,
    output logic [2:0]                fireEnemy,
    output logic [10:0]               fireX,
    output logic [10:0]               fireY,
    output logic [NUM_SLOTS-1:0]      slotBusy
);
    localparam logic [10:0] Y_MAX = 11'd479;

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;
    typedef struct packed {
        logic [1:0]  slot;
        logic [2:0]  enemy;
        logic [10:0] x;
        logic [10:0] y;
    } fire_req_t;

    state_t               state, state_nxt;
    fire_req_t            req, cand;
    logic [7:0]           cooldown;
    logic [2:0]           rr_ptr, scan_idx;
    logic [3:0]           scan_cnt;
    logic [7:0]           alive_pad;
    logic [87:0]          x_pad, y_pad;
    logic [6:0]           sel_base;
    logic [11:0]          y_sum;
    logic [1:0]           free_slot;
    logic                 any_free, hit;
    logic                 start_scan, scan_step, latch_req, ack;
    logic [NUM_SLOTS-1:0] alloc;

    // Pad enemy vectors to the 8-enemy maximum so scan_idx can index them directly.
    assign alive_pad = 8'(enemyAlive);
    assign x_pad     = 88'(enemyX);
    assign y_pad     = 88'(enemyY);
    assign sel_base  = 7'(scan_idx) * 7'd11;
    assign hit       = alive_pad[scan_idx];

    assign fireSlot  = req.slot;
    assign fireEnemy = req.enemy;
    assign fireX     = req.x;
    assign fireY     = req.y;

    always_comb begin
        y_sum      = {1'b0, y_pad[sel_base +: 11]} + 12'(OBJECT_HEIGHT_Y);
        cand.slot  = free_slot;
        cand.enemy = scan_idx;
        cand.x     = x_pad[sel_base +: 11] + 11'(OBJECT_WIDTH_X / 2);
        cand.y     = (y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[10:0];
    end

    // Lowest-index free slot wins; alloc marks the slot claimed by an accepted shot.
    always_comb begin
        free_slot = 2'd0;
        any_free  = 1'b0;
        alloc     = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (!slotBusy[s]) begin
                free_slot = 2'(s);
                any_free  = 1'b1;
            end
        end
        for (int s = 0; s < NUM_SLOTS; s++)
            alloc[s] = ack && (req.slot == 2'(s));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cooldown == 8'd0 && !pause && any_free) state_nxt = SCAN;
            SCAN:    if (!pause) begin
                         if (hit)                                    state_nxt = ISSUE;
                         else if (scan_cnt == 4'(NUM_ENEMIES - 1))  state_nxt = IDLE;
                     end
            ISSUE:   if (fireAck) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_scan = (state == IDLE) && (state_nxt == SCAN);
        scan_step  = (state == SCAN) && !pause && !hit;
        latch_req  = (state == SCAN) && (state_nxt == ISSUE);
        ack        = (state == ISSUE) && fireAck;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cooldown  <= 8'(FIRE_COOLDOWN);
            rr_ptr    <= 3'd0;
            scan_idx  <= 3'd0;
            scan_cnt  <= 4'd0;
            req       <= '0;
            fireValid <= 1'b0;
            slotBusy  <= '0;
        end else begin
            if (ack)
                cooldown <= 8'(FIRE_COOLDOWN);
            else if (startOfFrame && !pause && cooldown != 8'd0)
                cooldown <= cooldown - 8'd1;

            if (start_scan) begin
                scan_idx <= rr_ptr;
                scan_cnt <= 4'd0;
            end else if (scan_step) begin
                scan_idx <= (scan_idx == 3'(NUM_ENEMIES - 1)) ? 3'd0 : scan_idx + 3'd1;
                scan_cnt <= scan_cnt + 4'd1;
            end

            // Coordinates are frozen at the hit; later enemy motion or death does not cancel.
            if (latch_req) begin
                req       <= cand;
                fireValid <= 1'b1;
            end else if (ack) begin
                fireValid <= 1'b0;
                rr_ptr    <= (req.enemy == 3'(NUM_ENEMIES - 1)) ? 3'd0 : req.enemy + 3'd1;
            end

            slotBusy <= (slotBusy & ~slotDone) | alloc;
        end
    end
endmodule

// File: tb/tb_enemies_fire_scheduler.sv
// Bench for enemies_fire_scheduler: directed scenarios plus a randomized run,
// all compared each cycle against a shot-level reference model.
module tb_enemies_fire_scheduler;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam int CD = 40;

    logic                clk = 1'b0;
    logic                reset, startOfFrame, pause, fireAck;
    logic [N-1:0]        enemyAlive;
    logic [11*N-1:0]     enemyX, enemyY;
    logic [S-1:0]        slotDone;
    logic                fireValid;
    logic [1:0]          fireSlot;
    logic [2:0]          fireEnemy;
    logic [10:0]         fireX, fireY;
    logic [S-1:0]        slotBusy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    enemies_fire_scheduler #(
        .NUM_ENEMIES(N), .NUM_SLOTS(S), .FIRE_COOLDOWN(CD),
        .OBJECT_WIDTH_X(30), .OBJECT_HEIGHT_Y(30)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .pause(pause),
        .enemyAlive(enemyAlive), .enemyX(enemyX), .enemyY(enemyY),
        .slotDone(slotDone), .fireAck(fireAck), .fireValid(fireValid),
        .fireSlot(fireSlot), .fireEnemy(fireEnemy), .fireX(fireX), .fireY(fireY),
        .slotBusy(slotBusy)
    );

    // Reference model: a shot is either pending-scan (outcome known up front), issued, or absent.
    int       m_cd, m_rr, m_wait, m_tgt, m_enemy, m_slot, m_x, m_y;
    bit       m_scan, m_issue;
    bit [S-1:0] m_busy;
    int       cyc = 0, fr_len = 2, sof_seen = 0, zero_cyc = 0, vcyc = 0;
    bit       sof_en = 1'b1, auto_ack = 1'b1;

    function automatic int ex(int i);
        return int'(enemyX[11*i +: 11]);
    endfunction

    function automatic int ey(int i);
        return int'(enemyY[11*i +: 11]);
    endfunction

    task automatic set_xy(int i, int x, int y);
        enemyX[11*i +: 11] = 11'(x);
        enemyY[11*i +: 11] = 11'(y);
    endtask

    task automatic m_reset();
        m_cd = CD; m_rr = 0; m_scan = 0; m_issue = 0; m_busy = '0;
        m_enemy = 0; m_slot = 0; m_x = 0; m_y = 0; m_wait = 0; m_tgt = -1;
    endtask

    task automatic m_step();
        bit ackn;
        int cd0, lo, yy, idx;
        bit [S-1:0] b0;
        cd0 = m_cd; b0 = m_busy; ackn = m_issue && fireAck;
        lo = -1;
        for (int s = S - 1; s >= 0; s--) if (!b0[s]) lo = s;
        for (int s = 0; s < S; s++)
            if (ackn && s == m_slot) m_busy[s] = 1'b1;
            else if (slotDone[s])    m_busy[s] = 1'b0;
        if (ackn) m_cd = CD;
        else if (startOfFrame && !pause && m_cd > 0) m_cd--;
        if (m_issue) begin
            if (fireAck) begin m_issue = 0; m_rr = (m_enemy + 1) % N; end
        end else if (m_scan) begin
            if (!pause) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_scan = 0;
                    if (m_tgt >= 0) begin
                        m_issue = 1; m_enemy = m_tgt; m_slot = lo;
                        m_x = ex(m_tgt) + 15;
                        yy  = ey(m_tgt) + 30;
                        m_y = (yy > 479) ? 479 : yy;
                    end
                end
            end
        end else if (cd0 == 0 && !pause && lo >= 0) begin
            m_scan = 1; m_tgt = -1; m_wait = N;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (m_tgt < 0 && enemyAlive[idx]) begin m_tgt = idx; m_wait = k + 1; end
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit acked;
        startOfFrame = sof_en && (cyc % fr_len == fr_len - 1);
        if (auto_ack) fireAck = m_issue;
        @(posedge clk);
        cyc++;
        acked = m_issue && fireAck;
        if (acked) sof_seen = 0;
        else if (startOfFrame && !pause && sof_seen < CD) begin
            sof_seen++;
            if (sof_seen == CD) zero_cyc = cyc;
        end
        m_step();
        #1;
        chk("valid", 32'(fireValid), 32'(m_issue));
        chk("busy",  32'(slotBusy),  32'(m_busy));
        chk("enemy", 32'(fireEnemy), 32'(m_enemy));
        chk("slot",  32'(fireSlot),  32'(m_slot));
        chk("x",     32'(fireX),     32'(m_x));
        chk("y",     32'(fireY),     32'(m_y));
        slotDone     = '0;
        startOfFrame = 1'b0;
    endtask

    task automatic run_until_valid(int maxc);
        int n;
        n = 0;
        do begin tick(); n++; end while (fireValid !== 1'b1 && n < maxc);
        total++;
        assert (fireValid === 1'b1) else begin
            bad++;
            $error("FAIL wait_valid: fireValid=%b after %0d cycles, expected 1", fireValid, maxc);
        end
        vcyc = cyc;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        m_reset();
        sof_seen = 0;
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        logic [26:0] snap;
        bit changed;
        int n;
        reset = 1'b1; startOfFrame = 0; pause = 0; fireAck = 0; slotDone = '0;
        enemyAlive = '1; enemyX = '0; enemyY = '0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(fireValid), 0);
        chk("rst_busy",  32'(slotBusy),  0);
        chk("rst_enemy", 32'(fireEnemy), 0);
        chk("rst_slot",  32'(fireSlot),  0);
        chk("rst_x",     32'(fireX),     0);
        chk("rst_y",     32'(fireY),     0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_xy(i, 50 + 100 * i, 100 + 50 * i);

        // All alive: shots from 0 then 1 into slots 0 and 1, then starved until a slot frees.
        run_until_valid(200);
        chk("lat_shot1", vcyc, zero_cyc + 2);
        chk("en_shot1", 32'(fireEnemy), 0);
        chk("sl_shot1", 32'(fireSlot), 0);
        run_until_valid(200);
        chk("lat_shot2", vcyc, zero_cyc + 2);
        chk("en_shot2", 32'(fireEnemy), 1);
        chk("sl_shot2", 32'(fireSlot), 1);
        repeat (120) tick();
        chk("starved_valid", 32'(fireValid), 0);
        chk("starved_busy", 32'(slotBusy), 3);
        slotDone = 2'b01;
        run_until_valid(10);
        chk("en_shot3", 32'(fireEnemy), 2);
        chk("sl_shot3", 32'(fireSlot), 0);
        chk("x_shot3", 32'(fireX), 265);
        chk("y_shot3", 32'(fireY), 230);

        // No ack for 100 cycles with pause toggling: request must stay put.
        auto_ack = 1'b0; fireAck = 1'b0;
        snap = {fireSlot, fireEnemy, fireX, fireY};
        changed = 1'b0;
        repeat (100) begin
            pause = 1'($urandom_range(0, 1));
            tick();
            if ({fireSlot, fireEnemy, fireX, fireY} !== snap || fireValid !== 1'b1) changed = 1'b1;
        end
        pause = 1'b0;
        chk("hold_stable", 32'(changed), 0);

        // Async reset mid-handshake.
        #2 reset = 1'b1;
        #1;
        chk("rst_issue_valid", 32'(fireValid), 0);
        chk("rst_issue_busy",  32'(slotBusy),  0);
        m_reset();
        sof_seen = 0;
        @(negedge clk) reset = 1'b0;

        // Sparse alive mask, Y clamp, and cooldown frozen while paused.
        enemyAlive = 4'b1010;
        set_xy(1, 100, 460);
        set_xy(3, 100, 200);
        auto_ack = 1'b1;
        run_until_valid(200);
        chk("lat_sparse1", vcyc, zero_cyc + 3);
        chk("en_sparse1", 32'(fireEnemy), 1);
        chk("sl_sparse1", 32'(fireSlot), 0);
        chk("x_clamp", 32'(fireX), 115);
        chk("y_clamp", 32'(fireY), 479);
        tick();
        pause = 1'b1;
        repeat (20) tick();
        pause = 1'b0;
        run_until_valid(200);
        chk("lat_paused", vcyc, zero_cyc + 3);
        chk("en_sparse2", 32'(fireEnemy), 3);
        chk("sl_sparse2", 32'(fireSlot), 1);
        chk("y_noclamp", 32'(fireY), 230);

        // Nobody alive: scans come up empty; reviving enemy 2 gets a quick shot.
        do_reset();
        enemyAlive = '0;
        repeat (100) tick();
        chk("dead_valid", 32'(fireValid), 0);
        n = 0;
        while (m_scan && n < 10) begin tick(); n++; end
        enemyAlive = 4'b0100;
        run_until_valid(6);
        chk("revive_en", 32'(fireEnemy), 2);
        chk("revive_sl", 32'(fireSlot), 0);

        // Randomized traffic against the model.
        do_reset();
        auto_ack = 1'b0;
        enemyAlive = '1;
        for (int t = 0; t < 1500; t++) begin
            pause    = ($urandom_range(0, 7) == 0);
            fireAck  = ($urandom_range(0, 2) == 0);
            slotDone = ($urandom_range(0, 7) == 0) ? S'($urandom) : '0;
            if (!m_scan && $urandom_range(0, 9) == 0) enemyAlive = N'($urandom);
            if ($urandom_range(0, 4) == 0)
                set_xy($urandom_range(0, N - 1), $urandom_range(0, 639), $urandom_range(0, 479));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
